mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter LATENCY, default 2: cycles from request acceptance to mem_resp; legal range 1..15.
REQ-002 Parameter DEPTH_WORDS, default 256: number of 32-bit words stored; power of two.
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 mem_read  input  1  read request, held by initiator until mem_resp.
REQ-006 mem_write  input  1  write request, held by initiator until mem_resp.
REQ-007 mem_address  input  32  byte address; bits [1:0] ignored.
REQ-008 mem_wdata  input  32  write data.
REQ-009 mem_byte_enable  input  4  write byte lanes; bit i enables mem_wdata[8i+7:8i].
REQ-010 mem_rdata  output  32  read data, valid in the mem_resp cycle of a read.
REQ-011 mem_resp  output  1  one-cycle completion pulse.
REQ-012 proto_err  output  1  sticky protocol-violation flag.

Function
REQ-013 FSM states IDLE, WAIT, RESP; registered outputs only, no combinational input-to-output path.
REQ-014 IDLE: exactly one of mem_read/mem_write high at a posedge -> accept; capture address, wdata, byte_enable, op; load counter with LATENCY-1; go WAIT, or RESP directly if LATENCY=1.
REQ-015 WAIT: counter decrements each cycle; at 0 go RESP; request inputs ignored except for the abort check.
REQ-016 Accept in cycle t -> mem_resp high in cycle t+LATENCY for exactly one cycle, then IDLE.
REQ-017 Write commit: captured enabled bytes written to word captured_address[log2(DEPTH_WORDS)+1:2] on the edge entering RESP; disabled bytes unchanged.
REQ-018 Read: mem_rdata loaded on the edge entering RESP with the full word, ignoring byte_enable; held until the next read response.
REQ-019 Addresses beyond DEPTH_WORDS wrap by masking upper bits, with no error.
REQ-020 A request seen in the same cycle that mem_resp is high is not accepted; first acceptance is possible the following cycle, in IDLE.
REQ-021 mem_read and mem_write both high in IDLE -> no accept, no resp, proto_err set; remain IDLE.
REQ-022 Request deasserted while in WAIT -> proto_err set, transaction abandoned (no commit, no resp), return IDLE.
REQ-023 Request still held in the cycle after RESP is treated as a new request, issued back-to-back.
REQ-024 proto_err clears only on rst.

Reset
REQ-025 rst at posedge: state IDLE, counter 0, mem_resp 0, mem_rdata 32'h0, proto_err 0.
REQ-026 rst during WAIT abandons the transaction with no commit; rst has priority over all other events.
REQ-027 Storage contents are not cleared by rst; writes committed before rst persist.

Structure
REQ-028 FSM state enum mem_resp_state_t and the LATENCY_MAX=15 constant are placed in the shared rv32i_types package.
REQ-029 Byte-enabled storage is one sub-module, mem_resp_array (single port, synchronous write, per-byte enables); FSM, counter and capture registers stay in mem_responder.

Verification
REQ-030 LATENCY=2: write 0x100 data 0xDEADBEEF be 4'hF accepted at t -> resp at t+2 only; then read 0x100 -> rdata 0xDEADBEEF at resp.
REQ-031 Read-modify: write 0x104 0x11223344 be F, then write 0x104 0xAABBCCDD be 4'b0101 -> read 0x104 returns 0x11BB33DD.
REQ-032 Wrap: DEPTH_WORDS=256, write 0x400 0xCAFEF00D, read 0x000 -> 0xCAFEF00D; address low bits 2'b11 give the same word.
REQ-033 Protocol: read and write both high -> no resp for 10 cycles, proto_err=1; drop mem_read in WAIT -> no resp, proto_err stays 1 until rst.
REQ-034 rst asserted in WAIT of a write to 0x200 (0x0) -> resp never pulses, all outputs reset; subsequent read of 0x200 returns old value 0x0.
REQ-035 LATENCY=1, request held continuously for 3 reads -> resp pulses every 2 cycles, one pulse per transaction.

Source files
------------

// File: rtl/rv32i_types.sv
// rv32i_types: shared types and constants for the memory responder
package rv32i_types;
    localparam int LATENCY_MAX = 15;
    localparam int CNT_W = $clog2(LATENCY_MAX + 1);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_resp_state_t;
endpackage

// File: rtl/mem_resp_array.sv
// mem_resp_array: single-port word storage with per-byte write enables
module mem_resp_array #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [3:0]                     be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);
    logic [31:0] mem [DEPTH_WORDS];
    // byte-lane write; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (we)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    assign rdata = mem[addr];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency memory slave with protocol-violation detection
module mem_responder
    import rv32i_types::*;
#(
    parameter int LATENCY     = 2,
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_rdata,
    output logic        mem_resp,
    output logic        proto_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    mem_resp_state_t state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [AW-1:0] cap_idx, src_idx;
    logic [31:0] cap_wdata, src_wdata, arr_rdata;
    logic [3:0] cap_be, src_be;
    logic cap_wr, src_wr, held, req_one, req_both, enter_resp;
    logic unused_addr;
    assign unused_addr = ^{mem_address[31:AW+2], mem_address[1:0]};
    assign req_one = mem_read ^ mem_write;
    assign req_both = mem_read & mem_write;
    assign held = cap_wr ? mem_write : mem_read;
    // with LATENCY=1 the commit edge is the accept edge, so the live inputs feed the array
    assign src_wr = (state == IDLE) ? mem_write : cap_wr;
    assign src_idx = (state == IDLE) ? mem_address[AW+1:2] : cap_idx;
    assign src_wdata = (state == IDLE) ? mem_wdata : cap_wdata;
    assign src_be = (state == IDLE) ? mem_byte_enable : cap_be;
    assign enter_resp = (state_next == RESP) && !rst;

    mem_resp_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk   (clk),
        .we    (enter_resp && src_wr),
        .be    (src_be),
        .addr  (src_idx),
        .wdata (src_wdata),
        .rdata (arr_rdata)
    );

    // state register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_next;
    end

    // next-state: accept a single request, count down, abandon if the request drops
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (req_one) state_next = (LATENCY == 1) ? RESP : WAIT;
            WAIT:    state_next = !held ? IDLE : (cnt == CNT_W'(1)) ? RESP : WAIT;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // completion pulse comes straight from the state register
    always_comb begin
        mem_resp = (state == RESP);
    end

    // request capture on acceptance
    always_ff @(posedge clk) begin
        if (state == IDLE && req_one) begin
            cap_wr    <= mem_write;
            cap_idx   <= mem_address[AW+1:2];
            cap_wdata <= mem_wdata;
            cap_be    <= mem_byte_enable;
        end
    end

    // latency counter, sticky error flag and read-data register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            proto_err <= 1'b0;
            mem_rdata <= 32'h0;
        end else begin
            if (state == IDLE && req_one) cnt <= CNT_W'(LATENCY - 1);
            else if (state == WAIT) cnt <= cnt - 1'b1;
            if ((state == IDLE && req_both) || (state == WAIT && !held)) proto_err <= 1'b1;
            if (enter_resp && !src_wr) mem_rdata <= arr_rdata;
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scoreboard bench for mem_responder at LATENCY 2 and 1
module tb_mem_responder;
    logic clk = 1'b0, rst = 1'b0;
    logic rd = 1'b0, wr = 1'b0, resp, perr;
    logic [31:0] addr = '0, wdata = '0, rdata;
    logic [3:0] be = '0;
    logic r1 = 1'b0, w1 = 1'b0, resp1, perr1;
    logic [31:0] a1 = '0, d1 = '0, rdata1;
    logic [3:0] be1 = '0;
    int vectors = 0, errs = 0;
    logic [31:0] model [256];
    logic [31:0] q [$];
    logic [31:0] exp_v;
    logic [6:0] pat;
    logic seen;

    always #5 clk = ~clk;

    mem_responder #(.LATENCY(2), .DEPTH_WORDS(256)) dut (
        .clk(clk), .rst(rst), .mem_read(rd), .mem_write(wr), .mem_address(addr),
        .mem_wdata(wdata), .mem_byte_enable(be), .mem_rdata(rdata), .mem_resp(resp),
        .proto_err(perr)
    );

    mem_responder #(.LATENCY(1), .DEPTH_WORDS(256)) dut1 (
        .clk(clk), .rst(rst), .mem_read(r1), .mem_write(w1), .mem_address(a1),
        .mem_wdata(d1), .mem_byte_enable(be1), .mem_rdata(rdata1), .mem_resp(resp1),
        .proto_err(perr1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic xact(input string tag, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b);
        int lat;
        logic [31:0] e;
        if (r) q.push_back(model[a[9:2]]);
        if (w) for (int i = 0; i < 4; i++) if (b[i]) model[a[9:2]][8*i +: 8] = d[8*i +: 8];
        @(negedge clk);
        rd = r; wr = w; addr = a; wdata = d; be = b;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp && lat < 20);
        check({tag, "_latency"}, lat, 2);
        if (r) begin
            e = (q.size() > 0) ? q.pop_front() : 32'hx;
            check({tag, "_rdata"}, rdata, e);
        end
        rd = 1'b0; wr = 1'b0;
        @(negedge clk);
        check({tag, "_pulse_width"}, {31'b0, resp}, 0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_resp", {31'b0, resp}, 0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_proto_err", {31'b0, perr}, 0);
        rst = 1'b0;

        xact("wr100", 0, 1, 32'h100, 32'hDEADBEEF, 4'hF);
        xact("rd100", 1, 0, 32'h100, 32'h0, 4'h0);
        xact("wr104a", 0, 1, 32'h104, 32'h11223344, 4'hF);
        xact("wr104b", 0, 1, 32'h104, 32'hAABBCCDD, 4'b0101);
        xact("rd104", 1, 0, 32'h104, 32'h0, 4'h0);
        check("merge_value", model[65], 32'h11BB33DD);
        xact("wr400", 0, 1, 32'h400, 32'hCAFEF00D, 4'hF);
        xact("rd000", 1, 0, 32'h000, 32'h0, 4'h0);
        xact("rd003", 1, 0, 32'h003, 32'h0, 4'h0);
        xact("wr200", 0, 1, 32'h200, 32'h0, 4'hF);
        xact("rd104_again", 1, 0, 32'h104, 32'h0, 4'h0);

        @(negedge clk);
        rd = 1'b1; wr = 1'b1; addr = 32'h100;
        seen = 1'b0;
        repeat (10) begin @(negedge clk); seen |= resp; end
        rd = 1'b0; wr = 1'b0;
        check("both_no_resp", {31'b0, seen}, 0);
        check("both_proto_err", {31'b0, perr}, 1);

        @(negedge clk);
        rd = 1'b1; addr = 32'h100;
        @(negedge clk);
        rd = 1'b0;
        seen = 1'b0;
        repeat (10) begin @(negedge clk); seen |= resp; end
        check("drop_rd_no_resp", {31'b0, seen}, 0);
        check("drop_rd_proto_err", {31'b0, perr}, 1);

        @(negedge clk);
        wr = 1'b1; addr = 32'h104; wdata = 32'hFFFFFFFF; be = 4'hF;
        @(negedge clk);
        wr = 1'b0;
        seen = 1'b0;
        repeat (5) begin @(negedge clk); seen |= resp; end
        check("drop_wr_no_resp", {31'b0, seen}, 0);
        xact("rd104_after_abort", 1, 0, 32'h104, 32'h0, 4'h0);
        check("proto_err_sticky", {31'b0, perr}, 1);

        @(negedge clk);
        wr = 1'b1; addr = 32'h200; wdata = 32'h12345678; be = 4'hF;
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        @(negedge clk);
        seen |= resp;
        rst = 1'b0; wr = 1'b0;
        repeat (5) begin @(negedge clk); seen |= resp; end
        check("rst_no_resp", {31'b0, seen}, 0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_proto_err", {31'b0, perr}, 0);
        xact("rd200_after_rst", 1, 0, 32'h200, 32'h0, 4'h0);
        xact("rd100_persist", 1, 0, 32'h100, 32'h0, 4'h0);

        @(negedge clk);
        w1 = 1'b1; a1 = 32'h10; d1 = 32'h5A5A0001; be1 = 4'hF;
        @(negedge clk);
        check("l1_write_resp", {31'b0, resp1}, 1);
        w1 = 1'b0;
        @(negedge clk);
        check("l1_write_pulse_width", {31'b0, resp1}, 0);
        repeat (3) q.push_back(32'h5A5A0001);
        r1 = 1'b1;
        pat = '0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            pat[6-i] = resp1;
            if (resp1) begin
                exp_v = (q.size() > 0) ? q.pop_front() : 32'hx;
                check("l1_rdata", rdata1, exp_v);
            end
            if (i == 4) r1 = 1'b0;
        end
        check("l1_pulse_pattern", {25'b0, pat}, {25'b0, 7'b1010100});
        check("l1_all_popped", q.size(), 0);
        check("l1_proto_err", {31'b0, perr1}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
